mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit that drives the datapath ALU and its surrounding multiplexers, register file and memory port. It decodes the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback states, and issues the 3-bit `alu_op` in the encoding the ALU consumes. It handles variable-latency memory through a ready handshake, and it traps on illegal encodings.

## Interface
Parameters:
- `PC_STEP`, 4: byte increment applied to the PC at fetch. It is informational only, because the controller selects the constant-4 ALU input.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ir`  in  32  instruction register contents, valid from S_ID onward
- `alu_zero`  in  1  high when the current ALU result == 0
- `mem_ready`  in  1  memory completes the current read or write this cycle
- `mem_re`, `mem_we`  out  1  memory read/write request
- `ir_we`  out  1  latch the fetched word into the IR
- `pc_we`  out  1  update the PC
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target {pc[31:28], ir[25:0], 2'b00}
- `aluout_we`  out  1  latch the ALU result into ALUOut
- `alu_a_sel`  out  2  00 = pc, 01 = rs, 10 = rt
- `alu_b_sel`  out  3  000 = rt, 001 = const 4, 010 = sext imm, 011 = zext imm, 100 = zext shamt, 101 = sext imm << 2
- `alu_op`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 not
- `rf_we`  out  1  register file write
- `rf_dst_sel`  out  1  0 = rt, 1 = rd
- `rf_wd_sel`  out  1  0 = ALUOut, 1 = memory data
- `retire`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  high while in S_TRAP

## Operation
States: S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP.

**Reset.** The state becomes S_INIT and every output is 0. S_INIT moves to S_IF on the next edge unconditionally.

**S_IF.**
- `mem_re` = 1, `alu_a_sel` = pc, `alu_b_sel` = 4, `alu_op` = add.
- While `mem_ready` = 0, hold all outputs and stay in S_IF.
- In the cycle `mem_ready` = 1, pulse `ir_we` = 1 and `pc_we` = 1 with `pc_src` = 00, then go to S_ID.

**S_ID.**
- `alu_a_sel` = pc, `alu_b_sel` = 101, `alu_op` = add, `aluout_we` = 1 (branch target).
- An illegal opcode/funct goes to S_TRAP.
- `j` asserts `pc_we` with `pc_src` = 10 and `retire`, then goes to S_IF.
- Every other instruction goes to S_EX.

**S_EX, by instruction class.**
- R-type:
  - add 100000 → add; sub 100010 → sub; and 100100 → and; or 100101 → or; xor 100110 → xor.
  - a = rs, b = rt.
  - sll 000000 → shl; srl 000010 → shr. For shifts, a = rt and b = shamt.
  - `aluout_we` = 1, then go to S_WB.
- addi 001000 → add with sext imm; andi 001100, ori 001101, xori 001110 → and/or/xor with zext imm. `aluout_we` = 1, then go to S_WB.
- lw 100011 / sw 101011: rs + sext imm, `aluout_we` = 1, then go to S_MEM.
- beq 000100:
  - a = rs, b = rt, `alu_op` = sub.
  - `pc_we` = `alu_zero` with `pc_src` = 01.
  - Assert `retire`, then go to S_IF.

**S_MEM.**
- lw: `mem_re` = 1; on `mem_ready`, go to S_WB.
- sw: `mem_we` = 1; on `mem_ready`, assert `retire` and go to S_IF.
- Requests are held stable while waiting.

**S_WB.**
- `rf_we` = 1 and `retire` = 1, then go to S_IF.
- lw: `rf_wd_sel` = 1, `rf_dst_sel` = 0.
- R-type: `rf_dst_sel` = 1.
- I-arith: `rf_dst_sel` = 0.

**S_TRAP.** `illegal` = 1 and all other outputs are 0. The controller stays in S_TRAP until reset.

Outputs not listed for a state are 0; `alu_op` defaults to add.

## Timing
- Outputs are a combinational decode of the state register and `ir`. The state is registered.
- Cycle counts with zero wait states (`mem_ready` tied high):
  - j: 2
  - beq: 3
  - R-type and I-arith: 4
  - sw: 4
  - lw: 5
- Each wait cycle adds exactly one cycle in S_IF or S_MEM.
- `mem_ready` outside S_IF/S_MEM is ignored.
- `rst_n` low in any state, including mid-wait, forces S_INIT immediately. No write completes after reset assertion.
- `retire` is asserted exactly once per non-trapping instruction.

## Structure
- The shared header `ctrl_defs.vh` holds:
  - state encodings;
  - ALUOp codes, shared with the ALU;
  - opcode and funct constants;
  - `pc_src` / `alu_a_sel` / `alu_b_sel` codes.
- Sub-module `instr_decode` is combinational: it maps `ir` to {class, alu_op, imm_zext, is_shift, illegal}. `mc_ctrl` holds the FSM and the output decode.

## Test plan
- Reset, then release with `mem_ready` = 1 → outputs all 0 in S_INIT. The next cycle shows `mem_re` = 1 and `alu_op` = 000. `ir_we` and `pc_we` pulse together.
- `ir` = add $3,$1,$2 (0x00221820) → 4 cycles. In EX: `alu_op` 000, `alu_b_sel` 000. In WB: `rf_we` = 1, `rf_dst_sel` = 1, `retire` = 1.
- `ir` = lw (0x8C220004) with `mem_ready` low for 3 cycles in S_MEM → 8 cycles total. `mem_re` is held; WB has `rf_wd_sel` = 1.
- `ir` = beq with `alu_zero` = 1, then repeated with `alu_zero` = 0 → `pc_we` = 1 with `pc_src` 01 in the first case and `pc_we` = 0 in the second. Both take 3 cycles.
- `ir` = sll $2,$1,4 (0x00011100) → in EX: `alu_op` 101, `alu_a_sel` 10, `alu_b_sel` 100.
- `ir` = opcode 111111 → S_TRAP: `illegal` = 1 and no further requests. Separately, drop `rst_n` during an sw wait → `mem_we` drops to 0 immediately.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state, ALU op codes,
// opcode/funct constants and datapath mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP
  } state_e;

  // Encoding is consumed directly by the ALU.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_NOT = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_IARITH, CL_LW, CL_SW, CL_BEQ, CL_J
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] A_PC = 2'b00;
  localparam logic [1:0] A_RS = 2'b01;
  localparam logic [1:0] A_RT = 2'b10;

  localparam logic [2:0] B_RT     = 3'b000;
  localparam logic [2:0] B_FOUR   = 3'b001;
  localparam logic [2:0] B_SEXT   = 3'b010;
  localparam logic [2:0] B_ZEXT   = 3'b011;
  localparam logic [2:0] B_SHAMT  = 3'b100;
  localparam logic [2:0] B_BRANCH = 3'b101;

  typedef struct packed {
    iclass_e iclass;
    alu_op_e alu_op;
    logic    imm_zext;
    logic    is_shift;
    logic    illegal;
  } decode_t;

endpackage

// File: rtl/mc_ctrl_instr_decode.sv
// Combinational instruction decoder: maps the IR to instruction class,
// ALU operation, immediate/shift flavour and an illegal-encoding flag.
module instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output decode_t     dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir;

  assign opcode    = ir_i[31:26];
  assign funct     = ir_i[5:0];
  assign unused_ir = ^ir_i[25:6];

  always_comb begin
    dec_o = '{iclass: CL_RTYPE, alu_op: ALU_ADD, imm_zext: 1'b0,
              is_shift: 1'b0, illegal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_o.alu_op = ALU_ADD;
          FN_SUB:  dec_o.alu_op = ALU_SUB;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_SLL:  begin dec_o.alu_op = ALU_SHL; dec_o.is_shift = 1'b1; end
          FN_SRL:  begin dec_o.alu_op = ALU_SHR; dec_o.is_shift = 1'b1; end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI: dec_o.iclass = CL_IARITH;
      OP_ANDI: begin dec_o.iclass = CL_IARITH; dec_o.alu_op = ALU_AND; dec_o.imm_zext = 1'b1; end
      OP_ORI:  begin dec_o.iclass = CL_IARITH; dec_o.alu_op = ALU_OR;  dec_o.imm_zext = 1'b1; end
      OP_XORI: begin dec_o.iclass = CL_IARITH; dec_o.alu_op = ALU_XOR; dec_o.imm_zext = 1'b1; end
      OP_LW:   dec_o.iclass = CL_LW;
      OP_SW:   dec_o.iclass = CL_SW;
      OP_BEQ:  begin dec_o.iclass = CL_BEQ; dec_o.alu_op = ALU_SUB; end
      OP_J:    dec_o.iclass = CL_J;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: fetch/decode/execute/memory/writeback sequencer
// with ready-handshaked memory and a sticky trap on illegal encodings.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_re,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        aluout_we,
  output logic [1:0]  alu_a_sel,
  output logic [2:0]  alu_b_sel,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic        rf_dst_sel,
  output logic        rf_wd_sel,
  output logic        retire,
  output logic        illegal
);

  // PC increment comes from the constant-4 ALU input, not from this parameter.
  localparam int unsigned unused_pc_step = PC_STEP;

  state_e  state_q, state_d;
  decode_t dec;

  instr_decode u_decode (
    .ir_i  (ir),
    .dec_o (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (dec.illegal)              state_d = S_TRAP;
        else if (dec.iclass == CL_J)  state_d = S_IF;
        else                          state_d = S_EX;
      end
      S_EX: begin
        case (dec.iclass)
          CL_LW, CL_SW: state_d = S_MEM;
          CL_BEQ:       state_d = S_IF;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:  if (mem_ready) state_d = (dec.iclass == CL_LW) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    aluout_we  = 1'b0;
    alu_a_sel  = A_PC;
    alu_b_sel  = B_RT;
    alu_op     = ALU_ADD;
    rf_we      = 1'b0;
    rf_dst_sel = 1'b0;
    rf_wd_sel  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_re    = 1'b1;
        alu_b_sel = B_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_ID: begin
        alu_b_sel = B_BRANCH;
        aluout_we = 1'b1;
        if (!dec.illegal && dec.iclass == CL_J) begin
          pc_we  = 1'b1;
          pc_src = PC_SRC_JUMP;
          retire = 1'b1;
        end
      end
      S_EX: begin
        alu_a_sel = A_RS;
        aluout_we = 1'b1;
        case (dec.iclass)
          CL_RTYPE: begin
            alu_op = dec.alu_op;
            if (dec.is_shift) begin
              alu_a_sel = A_RT;
              alu_b_sel = B_SHAMT;
            end
          end
          CL_IARITH: begin
            alu_op    = dec.alu_op;
            alu_b_sel = dec.imm_zext ? B_ZEXT : B_SEXT;
          end
          CL_BEQ: begin
            alu_op    = ALU_SUB;
            aluout_we = 1'b0;
            pc_we     = alu_zero;
            pc_src    = PC_SRC_ALUOUT;
            retire    = 1'b1;
          end
          default: alu_b_sel = B_SEXT;
        endcase
      end
      S_MEM: begin
        if (dec.iclass == CL_LW) begin
          mem_re = 1'b1;
        end else begin
          mem_we = 1'b1;
          retire = mem_ready;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        rf_wd_sel  = (dec.iclass == CL_LW);
        rf_dst_sel = (dec.iclass == CL_RTYPE);
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: random instruction stream with random memory
// wait states, per-instruction summaries checked against a reference model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        alu_zero, mem_ready;
  logic        mem_re, mem_we, ir_we, pc_we, aluout_we, rf_we;
  logic        rf_dst_sel, rf_wd_sel, retire, illegal;
  logic [1:0]  pc_src, alu_a_sel;
  logic [2:0]  alu_b_sel, alu_op;

  mc_ctrl #(.PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .aluout_we(aluout_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .rf_wd_sel(rf_wd_sel), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_SLL = 5,
                 K_SRL = 6, K_ADDI = 7, K_ANDI = 8, K_ORI = 9, K_XORI = 10,
                 K_LW = 11, K_SW = 12, K_BEQ = 13, K_J = 14;

  typedef struct {
    int          kind;
    logic [31:0] word;
    int          wait_if;
    int          wait_mem;
    bit          zero;
  } plan_t;

  typedef struct packed {
    int cycles;  int id_sig;  int ex_sig;  int n_fetch;  int fetch_bad;
    int n_pcw;   int pcw_src; int n_rfw;   int rf_dst;   int rf_wd;
    int n_memw;  int n_memr;  int n_illegal;
  } rec_t;

  plan_t plan[$];
  rec_t  exp_q[$];
  int    checks = 0, errors = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int outs();
    logic [19:0] v;
    v = {mem_re, mem_we, ir_we, pc_we, pc_src, aluout_we, alu_a_sel, alu_b_sel,
         alu_op, rf_we, rf_dst_sel, rf_wd_sel, retire, illegal};
    return int'(v);
  endfunction

  function automatic int sig(input int we, input int op, input int a, input int b);
    return we * 256 + op * 32 + a * 8 + b;
  endfunction

  function automatic logic [31:0] encode(input int k);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tg;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom); tg = 26'($urandom);
    case (k)
      K_ADD:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      K_SUB:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      K_AND:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      K_OR:   return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      K_XOR:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      K_SLL:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      K_SRL:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      K_ADDI: return {6'h08, rs, rt, imm};
      K_ANDI: return {6'h0C, rs, rt, imm};
      K_ORI:  return {6'h0D, rs, rt, imm};
      K_XORI: return {6'h0E, rs, rt, imm};
      K_LW:   return {6'h23, rs, rt, imm};
      K_SW:   return {6'h2B, rs, rt, imm};
      K_BEQ:  return {6'h04, rs, rt, imm};
      default: return {6'h02, tg};
    endcase
  endfunction

  // Reference: what one instruction must look like from the outside.
  function automatic rec_t model(input plan_t p);
    rec_t e;
    e = '0;
    e.id_sig  = sig(1, 0, 0, 5);
    e.n_fetch = 1;
    e.n_memr  = 1;
    case (p.kind)
      K_ADD, K_SUB, K_AND, K_OR, K_XOR: begin
        e.cycles = 4; e.n_rfw = 1; e.rf_dst = 1;
        e.ex_sig = sig(1, (p.kind == K_ADD) ? 0 : (p.kind == K_SUB) ? 1 :
                          (p.kind == K_AND) ? 2 : (p.kind == K_OR) ? 3 : 4, 1, 0);
      end
      K_SLL, K_SRL: begin
        e.cycles = 4; e.n_rfw = 1; e.rf_dst = 1;
        e.ex_sig = sig(1, (p.kind == K_SLL) ? 5 : 6, 2, 4);
      end
      K_ADDI: begin e.cycles = 4; e.n_rfw = 1; e.ex_sig = sig(1, 0, 1, 2); end
      K_ANDI: begin e.cycles = 4; e.n_rfw = 1; e.ex_sig = sig(1, 2, 1, 3); end
      K_ORI:  begin e.cycles = 4; e.n_rfw = 1; e.ex_sig = sig(1, 3, 1, 3); end
      K_XORI: begin e.cycles = 4; e.n_rfw = 1; e.ex_sig = sig(1, 4, 1, 3); end
      K_LW: begin
        e.cycles = 5 + p.wait_mem; e.n_rfw = 1; e.rf_wd = 1; e.n_memr = 2;
        e.ex_sig = sig(1, 0, 1, 2);
      end
      K_SW: begin
        e.cycles = 4 + p.wait_mem; e.n_memw = 1; e.ex_sig = sig(1, 0, 1, 2);
      end
      K_BEQ: begin
        e.cycles = 3; e.ex_sig = sig(0, 1, 1, 0);
        if (p.zero) begin e.n_pcw = 1; e.pcw_src = 1; end
      end
      default: begin e.cycles = 2; e.n_pcw = 1; e.pcw_src = 2; end
    endcase
    e.cycles += p.wait_if;
    return e;
  endfunction

  // Monitor: builds one observed record per retire and scores it.
  initial begin
    rec_t o;
    rec_t e;
    int   cyc, since_f;
    bit   counting;
    o = '0; cyc = 0; since_f = 99; counting = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!counting && mem_re) counting = 1'b1;
        if (counting) begin
          cyc++;
          if (ir_we) begin
            since_f = 0;
            o.n_fetch++;
            if (!(pc_we && pc_src == 2'b00 && mem_re && mem_ready)) o.fetch_bad++;
          end else if (since_f < 99) since_f++;
          if (since_f == 1) o.id_sig = sig(aluout_we, alu_op, alu_a_sel, alu_b_sel);
          if (since_f == 2) o.ex_sig = sig(aluout_we, alu_op, alu_a_sel, alu_b_sel);
          if (pc_we && !ir_we) begin o.n_pcw++; o.pcw_src = pc_src; end
          if (rf_we) begin o.n_rfw++; o.rf_dst = rf_dst_sel; o.rf_wd = rf_wd_sel; end
          if (mem_we && mem_ready) o.n_memw++;
          if (mem_re && mem_ready) o.n_memr++;
          if (illegal) o.n_illegal++;
          if (retire) begin
            o.cycles = cyc;
            chk("exp_available", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("cycles", o.cycles, e.cycles);
              chk("id_sig", o.id_sig, e.id_sig);
              chk("ex_sig", o.ex_sig, e.ex_sig);
              chk("n_fetch", o.n_fetch, e.n_fetch);
              chk("fetch_pulse", o.fetch_bad, e.fetch_bad);
              chk("n_pc_we", o.n_pcw, e.n_pcw);
              chk("pc_src", o.pcw_src, e.pcw_src);
              chk("n_rf_we", o.n_rfw, e.n_rfw);
              chk("rf_dst_sel", o.rf_dst, e.rf_dst);
              chk("rf_wd_sel", o.rf_wd, e.rf_wd);
              chk("n_mem_write", o.n_memw, e.n_memw);
              chk("n_mem_read", o.n_memr, e.n_memr);
              chk("illegal_seen", o.n_illegal, e.n_illegal);
            end
            o = '0; cyc = 0; since_f = 99;
          end
        end
      end
    end
  end

  // Driver: issues planned instructions, answers requests after planned waits.
  task automatic run_plan(output bit timed_out);
    plan_t cur;
    int    cnt, guard;
    bit    r, fetched;
    r = 1'b1; cnt = 0; guard = 0; fetched = 1'b0; timed_out = 1'b1;
    cur = '{kind: 0, word: 32'h0, wait_if: 0, wait_mem: 0, zero: 1'b0};
    while (guard < 5000) begin
      @(posedge clk); #1;
      if (r) begin
        if (plan.size() == 0) begin timed_out = 1'b0; break; end
        cur = plan.pop_front();
        ir = cur.word; alu_zero = cur.zero;
        cnt = cur.wait_if; fetched = 1'b0;
        exp_q.push_back(model(cur));
      end
      if (mem_re || mem_we) begin
        if (cnt > 0) begin mem_ready = 1'b0; cnt--; end
        else begin
          mem_ready = 1'b1;
          if (!fetched) begin fetched = 1'b1; cnt = cur.wait_mem; end
        end
      end else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      r = retire;
      guard++;
    end
  endtask

  task automatic add_plan(input int k, input logic [31:0] w, input int wi, input int wm,
                          input bit z);
    plan_t p;
    p.kind = k; p.word = w; p.wait_if = wi; p.wait_mem = wm; p.zero = z;
    plan.push_back(p);
  endtask

  initial begin
    bit timed_out, found;
    rst_n = 1'b0; ir = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1 chk("init_outputs", outs(), 0);

    add_plan(K_ADD, 32'h00221820, 0, 0, 1'b0);
    add_plan(K_LW,  32'h8C220004, 0, 3, 1'b0);
    add_plan(K_BEQ, 32'h10220003, 0, 0, 1'b1);
    add_plan(K_BEQ, 32'h10220003, 0, 0, 1'b0);
    add_plan(K_SLL, 32'h00011100, 0, 0, 1'b0);
    add_plan(K_SW,  32'hAC220008, 0, 0, 1'b0);
    add_plan(K_J,   32'h08000010, 0, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 14);
      add_plan(k, encode(k), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    mon_en = 1'b1;
    run_plan(timed_out);
    mon_en = 1'b0;
    chk("driver_timeout", int'(timed_out), 0);
    chk("all_retired", exp_q.size(), 0);

    // Illegal opcode traps and stays quiet.
    rst_n = 1'b0;
    #1 chk("trap_reset_outputs", outs(), 0);
    ir = 32'hFC000000; mem_ready = 1'b1; alu_zero = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (illegal) found = 1'b1;
    end
    chk("trap_entered", int'(found), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("trap_quiet", outs(), 1);
    end

    // Reset during a store wait drops the write request at once.
    rst_n = 1'b0; ir = 32'hAC220008; mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_we) begin mem_ready = 1'b0; found = 1'b1; end
    end
    chk("sw_wait_reached", int'(found), 1);
    @(negedge clk);
    chk("sw_req_held", int'(mem_we), 1);
    @(posedge clk); #2;
    chk("sw_req_held2", int'(mem_we), 1);
    rst_n = 1'b0;
    #1 chk("sw_reset_drop", int'(mem_we), 0);
    chk("sw_reset_all_zero", outs(), 0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_reset_no_retire", int'(retire | mem_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
